fifo_arbiter: RTL and testbench

FIFO_ARBITER -- requirements
Module: fifo_arbiter

---
 rtl/fifo_arbiter_pkg.sv | 26 ++
 rtl/fifo_arbiter_rr_arb2.sv | 25 ++
 rtl/fifo_arbiter.sv | 128 ++++++++++++
 tb/tb_fifo_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arbiter_pkg.sv
// Shared definitions for the two-requester fifo arbiter:
// FSM encoding, operation/requester constants, legality helper.
package fifo_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  // Writes need room, reads need data.
  function automatic logic op_legal(
    input logic rw,
    input logic is_full,
    input logic not_empty
  );
    return (rw == RW_WRITE) ? !is_full : not_empty;
  endfunction

endpackage

// File: rtl/fifo_arbiter_rr_arb2.sv
// Two-input round-robin arbiter (module rr_arb2).
// Ports: req[1:0] in, prio in (0 favours A), gnt[1:0] out, next_prio out.
module rr_arb2
  import fifo_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt,
  output logic       next_prio
);

  always_comb begin
    gnt       = 2'b00;
    next_prio = prio;
    if (&req) begin
      gnt[ID_A] = (prio == ID_A);
      gnt[ID_B] = (prio == ID_B);
      // Only a contested grant rotates the priority.
      next_prio = ~prio;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/fifo_arbiter.sv
// Serialises read/write requests from two requesters onto one fifo port.
// Ports: pclk/clear, a_*/b_* request+ack, f_* fifo port, rdata, full/nempty.
module fifo_arbiter
  import fifo_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             pclk,
  input  logic             clear,
  input  logic             a_req,
  input  logic             a_rw,
  input  logic [WIDTH-1:0] a_wdata,
  input  logic             b_req,
  input  logic             b_rw,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             a_ack,
  output logic             b_ack,
  output logic             a_err,
  output logic             b_err,
  output logic [WIDTH-1:0] rdata,
  output logic             f_en,
  output logic             f_rw,
  output logic [WIDTH-1:0] f_wdata,
  input  logic [WIDTH-1:0] f_rdata,
  output logic             full,
  output logic             nempty
);

  localparam int CW = $clog2(DEPTH + 1);

  state_t           state_q, state_d;
  logic             id_q, id_d;
  logic             rw_q, rw_d;
  logic             err_q, err_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [CW-1:0]    count_q, count_d;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       next_prio;
  logic       legal;

  assign req    = {b_req, a_req};
  assign full   = (count_q == CW'(DEPTH));
  assign nempty = (count_q != '0);
  assign legal  = op_legal(rw_q, full, nempty);

  rr_arb2 u_arb (
    .req       (req),
    .prio      (prio_q),
    .gnt       (gnt),
    .next_prio (next_prio)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    rw_d    = rw_q;
    err_d   = err_q;
    prio_d  = prio_q;
    wdata_d = wdata_q;
    count_d = count_q;
    f_en    = 1'b0;
    f_rw    = 1'b0;
    f_wdata = '0;
    a_ack   = 1'b0;
    b_ack   = 1'b0;
    a_err   = 1'b0;
    b_err   = 1'b0;
    rdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          id_d    = gnt[ID_B] ? ID_B : ID_A;
          rw_d    = gnt[ID_B] ? b_rw : a_rw;
          wdata_d = gnt[ID_B] ? b_wdata : a_wdata;
          prio_d  = next_prio;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        err_d = !legal;
        if (legal) begin
          f_en    = 1'b1;
          f_rw    = rw_q;
          f_wdata = wdata_q;
          count_d = (rw_q == RW_WRITE) ? count_q + CW'(1)
                                       : count_q - CW'(1);
        end
        state_d = CAPTURE;
      end
      CAPTURE: begin
        a_ack = (id_q == ID_A);
        b_ack = (id_q == ID_B);
        a_err = a_ack & err_q;
        b_err = b_ack & err_q;
        if (rw_q == RW_READ && !err_q) begin
          rdata = f_rdata;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      id_q    <= ID_A;
      rw_q    <= RW_READ;
      err_q   <= 1'b0;
      prio_q  <= 1'b0;
      wdata_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      rw_q    <= rw_d;
      err_q   <= err_d;
      prio_q  <= prio_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter with an external 4-word fifo model
// and a scoreboard for the two-requester streaming phase.
module tb_fifo_arbiter;

  logic       pclk = 1'b0;
  logic       clear;
  logic       a_req, a_rw, b_req, b_rw;
  logic [7:0] a_wdata, b_wdata;
  logic       a_ack, b_ack, a_err, b_err;
  logic [7:0] rdata, f_wdata, f_rdata;
  logic       f_en, f_rw, full, nempty;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  fifo_arbiter #(.WIDTH(8), .DEPTH(4)) dut (
    .pclk    (pclk),
    .clear   (clear),
    .a_req   (a_req),
    .a_rw    (a_rw),
    .a_wdata (a_wdata),
    .b_req   (b_req),
    .b_rw    (b_rw),
    .b_wdata (b_wdata),
    .a_ack   (a_ack),
    .b_ack   (b_ack),
    .a_err   (a_err),
    .b_err   (b_err),
    .rdata   (rdata),
    .f_en    (f_en),
    .f_rw    (f_rw),
    .f_wdata (f_wdata),
    .f_rdata (f_rdata),
    .full    (full),
    .nempty  (nempty)
  );

  // external fifo, cleared by the same clear
  logic [7:0] fmem [4];
  logic [1:0] wp, rp;

  always @(posedge pclk or negedge clear) begin
    if (!clear) begin
      wp      <= 2'd0;
      rp      <= 2'd0;
      f_rdata <= 8'h00;
    end else if (f_en) begin
      if (f_rw) begin
        fmem[wp] <= f_wdata;
        wp       <= wp + 2'd1;
      end else begin
        f_rdata <= fmem[rp];
        rp      <= rp + 2'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic do_op(input logic who, input logic rw,
                       input logic [7:0] wd, input logic want_err,
                       input logic [7:0] want_rd, input string tag);
    int lat;
    int fen;
    bit got;
    lat = 0;
    fen = 0;
    got = 1'b0;
    @(negedge pclk);
    if (who) begin
      b_req = 1'b1; b_rw = rw; b_wdata = wd;
    end else begin
      a_req = 1'b1; a_rw = rw; a_wdata = wd;
    end
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge pclk);
      lat++;
      if (f_en) fen++;
      if (who ? b_ack : a_ack) begin
        got = 1'b1;
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_err"}, who ? b_err : a_err, want_err);
        if (rw == 1'b0) chk({tag, "_rdata"}, rdata, want_rd);
        a_req = 1'b0;
        b_req = 1'b0;
      end
    end
    chk({tag, "_ack"}, got, 1);
    chk({tag, "_fen"}, fen, want_err ? 0 : 1);
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  // streaming scoreboard
  logic [7:0] q [$];
  int m    = 0;
  int ops  = 0;
  int last = -1;

  task automatic serve(input logic who, input logic rw,
                       input logic [7:0] wd, input logic err_obs,
                       input logic [7:0] rd_obs);
    logic legal;
    logic [7:0] want;
    legal = rw ? (m < 4) : (m > 0);
    chk("str_err", err_obs, !legal);
    if (legal && rw) begin
      q.push_back(wd);
      m++;
    end else if (legal) begin
      want = q.pop_front();
      chk("str_rdata", rd_obs, want);
      m--;
    end else if (!rw) begin
      chk("str_rdata_ill", rd_obs, 0);
    end
    if (last < 0) chk("str_first", who, 0);
    else chk("str_fair", who, (last == 0) ? 1 : 0);
    last = who;
    ops++;
  endtask

  initial begin
    int ta, tb, cyc;
    logic [1:0] st;
    a_req = 0; a_rw = 0; a_wdata = 0;
    b_req = 0; b_rw = 0; b_wdata = 0;
    clear = 1'b1;
    #2 clear = 1'b0;
    @(negedge pclk);
    chk("rst_flags", {a_ack, b_ack, a_err, b_err, f_en, f_rw, full, nempty}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_fwdata", f_wdata, 0);
    chk("rst_count", dut.count_q, 0);
    chk("rst_prio", dut.prio_q, 0);
    st = dut.state_q;
    chk("rst_state", st, 0);
    clear = 1'b1;

    do_op(0, 0, 8'h00, 1, 8'h00, "rd_empty");
    chk("rd_empty_count", dut.count_q, 0);

    do_op(0, 1, 8'h63, 0, 0, "wr0");
    do_op(0, 1, 8'h61, 0, 0, "wr1");
    do_op(0, 1, 8'h74, 0, 0, "wr2");
    do_op(0, 1, 8'h73, 0, 0, "wr3");
    chk("full_set", full, 1);
    chk("nempty_set", nempty, 1);
    do_op(0, 1, 8'h62, 1, 0, "wr_full");
    chk("wr_full_count", dut.count_q, 4);

    do_op(1, 0, 0, 0, 8'h63, "rd0");
    do_op(1, 0, 0, 0, 8'h61, "rd1");
    do_op(1, 0, 0, 0, 8'h74, "rd2");
    do_op(1, 0, 0, 0, 8'h73, "rd3");
    chk("nempty_clr", nempty, 0);
    chk("full_clr", full, 0);

    // contested grant from prio 0
    chk("both_prio0", dut.prio_q, 0);
    ta = 0; tb = 0; cyc = 0;
    @(negedge pclk);
    a_req = 1; a_rw = 1; a_wdata = 8'h62;
    b_req = 1; b_rw = 1; b_wdata = 8'h69;
    for (int i = 0; i < 20 && (ta == 0 || tb == 0); i++) begin
      @(negedge pclk);
      cyc++;
      if (a_ack) begin
        ta = cyc; a_req = 0;
        chk("both_a_err", a_err, 0);
      end
      if (b_ack) begin
        tb = cyc; b_req = 0;
        chk("both_b_err", b_err, 0);
      end
    end
    a_req = 0; b_req = 0;
    chk("both_a_time", ta, 2);
    chk("both_b_time", tb, 5);
    chk("both_prio1", dut.prio_q, 1);
    chk("both_count", dut.count_q, 2);
    do_op(0, 0, 0, 0, 8'h62, "both_rb0");
    do_op(0, 0, 0, 0, 8'h69, "both_rb1");

    // clear during ISSUE of a write
    @(negedge pclk);
    a_req = 1; a_rw = 1; a_wdata = 8'h55;
    @(negedge pclk);
    chk("clr_fen_issue", f_en, 1);
    clear = 1'b0;
    #1;
    chk("clr_fen", f_en, 0);
    chk("clr_count", dut.count_q, 0);
    chk("clr_ack", a_ack, 0);
    a_req = 0;
    repeat (2) begin
      @(negedge pclk);
      chk("clr_ack_low", a_ack, 0);
    end
    clear = 1'b1;
    repeat (3) begin
      @(negedge pclk);
      chk("clr_ack_after", {a_ack, b_ack, nempty}, 0);
    end

    // both requesters streaming
    q.delete();
    m = 0; ops = 0; last = -1;
    a_rw = 1'($urandom_range(0, 1)); a_wdata = 8'($urandom);
    b_rw = 1'($urandom_range(0, 1)); b_wdata = 8'($urandom);
    a_req = 1; b_req = 1;
    for (int c = 0; c < 400 && ops < 100; c++) begin
      @(negedge pclk);
      if (a_ack) begin
        serve(0, a_rw, a_wdata, a_err, rdata);
        a_rw = 1'($urandom_range(0, 1)); a_wdata = 8'($urandom);
      end
      if (b_ack) begin
        serve(1, b_rw, b_wdata, b_err, rdata);
        b_rw = 1'($urandom_range(0, 1)); b_wdata = 8'($urandom);
      end
      chk("str_count", dut.count_q, m);
    end
    a_req = 0; b_req = 0;
    chk("str_done", ops, 100);

    repeat (4) @(negedge pclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
